enqueue_agent_v0_2: RTL and testbench

Parametrised successor of the v0.1 enqueue agent. Sits between the pipeline output (AXIS beats plus SUME metadata) and the per-port packet buffers and PIFO calendars. It decodes the one-hot destination mask from tuser and writes each packet beat into every selected port buffer. It issues one PIFO insert per packet per port and applies either drop or backpressure policy when a target port is full. It also keeps saturating per-port drop counters.

---
 rtl/enqueue_agent_v0_2_pkg.sv | 16 +
 rtl/enqueue_agent_v0_2_sat_counter.sv | 23 ++
 rtl/enqueue_agent_v0_2.sv | 136 +++++++++++++
 tb/tb_enqueue_agent_v0_2.sv | 366 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/enqueue_agent_v0_2_pkg.sv
// Shared definitions for the enqueue agent: FSM encoding, full-policy
// selectors and the default SUME destination-mask offset.
package enq_agent_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,   // waiting for the head beat of a packet
        ST_FWD  = 2'd1,   // forwarding body beats to the latched ports
        ST_DROP = 2'd2    // consuming body beats of a packet nobody takes
    } enq_state_t;

    localparam int FULL_MODE_DROP = 0;   // drop on each full port, partial multicast
    localparam int FULL_MODE_BP   = 1;   // hold the head until all destinations are free

    localparam int SUME_DST_LSB = 24;    // one-hot destination mask offset in tuser

endpackage

// File: rtl/enqueue_agent_v0_2_sat_counter.sv
// Saturating up-counter with asynchronous active-low clear.
module sat_counter #(
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 inc,
    output logic [CNT_WIDTH-1:0] cnt
);

    localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};

    // count up by one per request, holding at all-ones
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (inc && (cnt != CNT_MAX)) begin
            cnt <= cnt + CNT_ONE;
        end
    end

endmodule

// File: rtl/enqueue_agent_v0_2.sv
// Enqueue agent: fans each AXIS packet out to the per-port buffers selected
// by the one-hot destination mask in tuser, issues one PIFO insert per packet
// per port, and counts packets dropped on full ports.
//
// Handshake: a beat transfers on a rising edge where s_axis_tvalid and
// s_axis_tready are both high; tready never depends on anything registered
// downstream, and all enables appear one cycle after the transferring beat.
module enqueue_agent_v0_2
    import enq_agent_pkg::*;
#(
    parameter int NUM_PORTS   = 5,
    parameter int TUSER_WIDTH = 128,
    parameter int DST_LSB     = SUME_DST_LSB,
    parameter int FULL_MODE   = FULL_MODE_DROP,
    parameter int CNT_WIDTH   = 16
) (
    input  logic                           axis_aclk,
    input  logic                           axis_resetn,
    input  logic                           s_axis_tvalid,
    output logic                           s_axis_tready,
    input  logic [TUSER_WIDTH-1:0]         s_axis_tuser,
    input  logic                           s_axis_tlast,
    input  logic                           s_axis_tpifo_valid,
    input  logic [NUM_PORTS-1:0]           s_axis_buffer_almost_full,
    input  logic [NUM_PORTS-1:0]           s_axis_pifo_full,
    output logic                           m_axis_valid,
    output logic [NUM_PORTS-1:0]           m_axis_ctl_pifo_in_en,
    output logic [NUM_PORTS-1:0]           m_axis_ctl_buffer_wr_en,
    output logic [NUM_PORTS*CNT_WIDTH-1:0] m_drop_count,
    output enq_state_t                     dbg_state
);

    enq_state_t           state_q, state_d;
    logic [NUM_PORTS-1:0] dst, free, head_mask;
    logic [NUM_PORTS-1:0] mask_q, mask_d;
    logic [NUM_PORTS-1:0] wr_q, wr_d;
    logic [NUM_PORTS-1:0] pifo_q, pifo_d;
    logic [NUM_PORTS-1:0] drop_inc;
    logic                 accept;

    assign dst    = s_axis_tuser[DST_LSB +: NUM_PORTS];
    assign free   = ~s_axis_buffer_almost_full & ~s_axis_pifo_full;
    assign accept = s_axis_tvalid & s_axis_tready;

    // In backpressure mode the head already waits for every destination,
    // so the whole destination mask is taken; otherwise only free ports.
    assign head_mask = (FULL_MODE == FULL_MODE_BP) ? dst : (dst & free);

    // ready: held low in reset; in backpressure mode a head with any full
    // destination is stalled, every other beat is taken immediately
    always_comb begin
        s_axis_tready = 1'b0;
        if (axis_resetn) begin
            if ((state_q == ST_IDLE) && (FULL_MODE == FULL_MODE_BP)) begin
                s_axis_tready = ~(s_axis_tvalid & (|(dst & ~free)));
            end else begin
                s_axis_tready = 1'b1;
            end
        end
    end

    // next state, latched mask, enables and per-port drop requests
    always_comb begin
        state_d  = state_q;
        mask_d   = mask_q;
        wr_d     = '0;
        pifo_d   = '0;
        drop_inc = '0;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    mask_d = head_mask;
                    if (FULL_MODE == FULL_MODE_DROP) begin
                        drop_inc = dst & ~free;
                    end
                    if (|head_mask) begin
                        wr_d    = head_mask;
                        pifo_d  = s_axis_tpifo_valid ? head_mask : '0;
                        state_d = s_axis_tlast ? ST_IDLE : ST_FWD;
                    end else begin
                        state_d = s_axis_tlast ? ST_IDLE : ST_DROP;
                    end
                end
            end
            ST_FWD: begin
                if (accept) begin
                    wr_d = mask_q;
                    if (s_axis_tlast) begin
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_DROP: begin
                if (accept && s_axis_tlast) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // state, latched mask and registered enables
    always_ff @(posedge axis_aclk or negedge axis_resetn) begin
        if (!axis_resetn) begin
            state_q <= ST_IDLE;
            mask_q  <= '0;
            wr_q    <= '0;
            pifo_q  <= '0;
        end else begin
            state_q <= state_d;
            mask_q  <= mask_d;
            wr_q    <= wr_d;
            pifo_q  <= pifo_d;
        end
    end

    assign m_axis_ctl_buffer_wr_en = wr_q;
    assign m_axis_ctl_pifo_in_en   = pifo_q;
    assign m_axis_valid            = |wr_q;
    assign dbg_state               = state_q;

    // one saturating drop counter per port, packed port 0 in the LSBs
    for (genvar g = 0; g < NUM_PORTS; g++) begin : g_drop_cnt
        sat_counter #(
            .CNT_WIDTH (CNT_WIDTH)
        ) u_cnt (
            .clk   (axis_aclk),
            .rst_n (axis_resetn),
            .inc   (drop_inc[g]),
            .cnt   (m_drop_count[g*CNT_WIDTH +: CNT_WIDTH])
        );
    end

endmodule

// File: tb/tb_enqueue_agent_v0_2.sv
// Bench for enqueue_agent_v0_2: instance 0 runs the drop policy with 2-bit
// counters, instance 1 the backpressure policy with 4-bit counters. A
// packet-level model predicts every output each cycle; directed scenarios
// pin the model with hand-computed values, then random traffic runs on both.
module tb_enqueue_agent_v0_2;
  import enq_agent_pkg::*;

  localparam int NP  = 5;
  localparam int TW  = 128;
  localparam int DL  = 24;
  localparam int CW0 = 2;
  localparam int CW1 = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          tvalid[2];
  logic          tlast[2];
  logic          tpv[2];
  logic [TW-1:0] tuser[2];
  logic [NP-1:0] baf[2];
  logic [NP-1:0] pff[2];
  logic          tready[2];
  logic          mvalid[2];
  logic [NP-1:0] pifo_en[2];
  logic [NP-1:0] wr_en[2];
  logic [NP*CW0-1:0] cnt0;
  logic [NP*CW1-1:0] cnt1;
  enq_state_t    st[2];

  enqueue_agent_v0_2 #(
    .NUM_PORTS(NP), .TUSER_WIDTH(TW), .DST_LSB(DL),
    .FULL_MODE(FULL_MODE_DROP), .CNT_WIDTH(CW0)
  ) dut0 (
    .axis_aclk(clk), .axis_resetn(rst_n),
    .s_axis_tvalid(tvalid[0]), .s_axis_tready(tready[0]),
    .s_axis_tuser(tuser[0]), .s_axis_tlast(tlast[0]),
    .s_axis_tpifo_valid(tpv[0]),
    .s_axis_buffer_almost_full(baf[0]), .s_axis_pifo_full(pff[0]),
    .m_axis_valid(mvalid[0]), .m_axis_ctl_pifo_in_en(pifo_en[0]),
    .m_axis_ctl_buffer_wr_en(wr_en[0]), .m_drop_count(cnt0),
    .dbg_state(st[0])
  );

  enqueue_agent_v0_2 #(
    .NUM_PORTS(NP), .TUSER_WIDTH(TW), .DST_LSB(DL),
    .FULL_MODE(FULL_MODE_BP), .CNT_WIDTH(CW1)
  ) dut1 (
    .axis_aclk(clk), .axis_resetn(rst_n),
    .s_axis_tvalid(tvalid[1]), .s_axis_tready(tready[1]),
    .s_axis_tuser(tuser[1]), .s_axis_tlast(tlast[1]),
    .s_axis_tpifo_valid(tpv[1]),
    .s_axis_buffer_almost_full(baf[1]), .s_axis_pifo_full(pff[1]),
    .m_axis_valid(mvalid[1]), .m_axis_ctl_pifo_in_en(pifo_en[1]),
    .m_axis_ctl_buffer_wr_en(wr_en[1]), .m_drop_count(cnt1),
    .dbg_state(st[1])
  );

  // ---------------- bookkeeping ----------------
  int total = 0;
  int bad = 0;
  int cyc = 0;
  int w;
  bit rand_en = 0;
  bit saw_drop = 0;
  logic [10:0] hist0[$];
  logic [10:0] hist1[$];
  int          hcyc0[$];
  logic [10:0] eh[$];

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Packet-level view: a packet either goes to the ports chosen at its head
  // (possibly none) or is waiting for its head; counters follow drops.
  bit          in_pkt[2];
  logic [NP-1:0] m_mask[2];
  logic [NP-1:0] e_wr[2];
  logic [NP-1:0] e_pifo[2];
  int          e_cnt[2][NP];

  function automatic bit mode_bp(int i);
    return (i == 1);
  endfunction

  function automatic int cmax(int i);
    return (i == 0) ? ((1 << CW0) - 1) : ((1 << CW1) - 1);
  endfunction

  function automatic bit exp_ready(int i);
    logic [NP-1:0] d;
    logic [NP-1:0] f;
    if (!rst_n) return 1'b0;
    if (in_pkt[i] || !mode_bp(i)) return 1'b1;
    d = tuser[i][DL +: NP];
    f = ~baf[i] & ~pff[i];
    return !(tvalid[i] && ((d & ~f) != '0));
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        in_pkt[i] = 0;
        m_mask[i] = '0;
        e_wr[i] = '0;
        e_pifo[i] = '0;
        for (int p = 0; p < NP; p++) e_cnt[i][p] = 0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        logic [NP-1:0] d;
        logic [NP-1:0] f;
        logic [NP-1:0] nwr;
        logic [NP-1:0] npf;
        bit acc;
        acc = tvalid[i] && exp_ready(i);
        nwr = '0;
        npf = '0;
        if (acc) begin
          if (!in_pkt[i]) begin
            d = tuser[i][DL +: NP];
            f = ~baf[i] & ~pff[i];
            m_mask[i] = mode_bp(i) ? d : (d & f);
            if (!mode_bp(i)) begin
              for (int p = 0; p < NP; p++)
                if (d[p] && !f[p] && e_cnt[i][p] < cmax(i)) e_cnt[i][p]++;
            end
            nwr = m_mask[i];
            npf = tpv[i] ? m_mask[i] : '0;
          end else begin
            nwr = m_mask[i];
          end
          in_pkt[i] = !tlast[i];
        end
        e_wr[i] = nwr;
        e_pifo[i] = npf;
      end
    end
  end

  always @(posedge clk) cyc++;

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    #2;
    for (int i = 0; i < 2; i++) begin
      enq_state_t es;
      es = !in_pkt[i] ? ST_IDLE : ((m_mask[i] != '0) ? ST_FWD : ST_DROP);
      chk($sformatf("tready%0d", i), 32'(tready[i]), 32'(exp_ready(i)));
      chk($sformatf("wr_en%0d", i), 32'(wr_en[i]), 32'(e_wr[i]));
      chk($sformatf("pifo_en%0d", i), 32'(pifo_en[i]), 32'(e_pifo[i]));
      chk($sformatf("valid%0d", i), 32'(mvalid[i]), 32'(e_wr[i] != '0));
      chk($sformatf("state%0d", i), 32'(st[i]), 32'(es));
    end
    for (int p = 0; p < NP; p++) begin
      chk($sformatf("cnt0_p%0d", p), 32'(cnt0[p*CW0 +: CW0]), 32'(e_cnt[0][p]));
      chk($sformatf("cnt1_p%0d", p), 32'(cnt1[p*CW1 +: CW1]), 32'(e_cnt[1][p]));
    end
    if (mvalid[0] || wr_en[0] != '0 || pifo_en[0] != '0) begin
      hist0.push_back({mvalid[0], pifo_en[0], wr_en[0]});
      hcyc0.push_back(cyc);
    end
    if (mvalid[1] || wr_en[1] != '0 || pifo_en[1] != '0)
      hist1.push_back({mvalid[1], pifo_en[1], wr_en[1]});
    if (st[0] == ST_DROP) saw_drop = 1;
  end

  // random full flags during the random phase
  always @(negedge clk) begin
    if (rand_en) begin
      for (int i = 0; i < 2; i++) begin
        baf[i] = NP'($urandom & $urandom);
        pff[i] = NP'($urandom & $urandom);
      end
    end
  end

  // ---------------- driver tasks ----------------
  // All tasks start and end on a falling edge.
  task automatic send_beat(int i, logic [NP-1:0] d, logic last, logic pv, output int waits);
    waits = 0;
    tvalid[i] = 1'b1;
    tuser[i] = {$urandom, $urandom, $urandom, $urandom};
    tuser[i][DL +: NP] = d;
    tlast[i] = last;
    tpv[i] = pv;
    #1;
    while (!tready[i]) begin
      @(negedge clk);
      waits++;
      if (waits > 300) begin
        total++;
        bad++;
        $display("FAIL ready_timeout%0d actual=stalled required=accepted t=%0t", i, $time);
        tvalid[i] = 1'b0;
        return;
      end
      #1;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic send_pkt(int i, logic [NP-1:0] d, int len, logic pv);
    int wt;
    for (int b = 0; b < len; b++) send_beat(i, d, (b == len - 1), pv, wt);
  endtask

  task automatic idle(int i, int n);
    tvalid[i] = 1'b0;
    tlast[i] = 1'b0;
    tpv[i] = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    for (int i = 0; i < 2; i++) begin
      tvalid[i] = 1'b0; tlast[i] = 1'b0; tpv[i] = 1'b0;
      tuser[i] = '0; baf[i] = '0; pff[i] = '0;
    end
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic chk_hist(string name, int i);
    int n;
    n = (i == 0) ? hist0.size() : hist1.size();
    chk({name, "_len"}, 32'(n), 32'(eh.size()));
    for (int k = 0; k < eh.size() && k < n; k++)
      chk($sformatf("%s_%0d", name, k), 32'((i == 0) ? hist0[k] : hist1[k]), 32'(eh[k]));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    for (int i = 0; i < 2; i++) begin
      tvalid[i] = 1'b0; tlast[i] = 1'b0; tpv[i] = 1'b0;
      tuser[i] = '0; baf[i] = '0; pff[i] = '0;
    end
    repeat (3) @(negedge clk);
    #1;
    chk("rst_tready", 32'(tready[0]), 32'd0);
    chk("rst_cnt0", 32'(cnt0), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // single-destination three-beat packet with a PIFO rank
    hist0.delete();
    send_pkt(0, 5'b00100, 3, 1'b1);
    idle(0, 3);
    eh = '{11'h484, 11'h404, 11'h404};
    chk_hist("t1", 0);

    // multicast with one port almost full
    do_reset();
    hist0.delete();
    baf[0] = 5'b00100;
    send_pkt(0, 5'b10101, 2, 1'b1);
    idle(0, 3);
    baf[0] = '0;
    eh = '{11'h631, 11'h411};
    chk_hist("t2", 0);
    chk("t2_cnt", 32'(cnt0), 32'h010);

    // backpressure instance holds the head for four cycles
    do_reset();
    hist1.delete();
    pff[1] = 5'b00010;
    fork
      send_beat(1, 5'b00010, 1'b1, 1'b0, w);
      begin
        repeat (4) @(negedge clk);
        pff[1] = '0;
      end
    join
    idle(1, 3);
    chk("t3_wait", 32'(w), 32'd4);
    eh = '{11'h402};
    chk_hist("t3", 1);
    chk("t3_cnt", 32'(cnt1), 32'd0);

    // empty destination mask: consumed silently through DROP
    do_reset();
    hist0.delete();
    saw_drop = 0;
    send_pkt(0, 5'b00000, 4, 1'b1);
    idle(0, 3);
    chk("t4_len", 32'(hist0.size()), 32'd0);
    chk("t4_drop_state", 32'(saw_drop), 32'd1);
    chk("t4_cnt", 32'(cnt0), 32'd0);

    // back-to-back single-beat packets
    do_reset();
    hist0.delete();
    hcyc0.delete();
    for (int p = 0; p < 4; p++) send_beat(0, NP'(1 << p), 1'b1, 1'b0, w);
    idle(0, 3);
    eh = '{11'h401, 11'h402, 11'h404, 11'h408};
    chk_hist("t5", 0);
    for (int k = 1; k < 4 && k < hcyc0.size(); k++)
      chk($sformatf("t5_gap%0d", k), 32'(hcyc0[k] - hcyc0[0]), 32'(k));

    // saturation and reset mid-packet
    do_reset();
    baf[0] = 5'b01000;
    repeat (5) send_pkt(0, 5'b01000, 2, 1'b0);
    baf[0] = '0;
    idle(0, 2);
    chk("t6_sat", 32'(cnt0), 32'h0C0);
    send_beat(0, 5'b00001, 1'b0, 1'b1, w);
    tvalid[0] = 1'b1;
    tlast[0] = 1'b0;
    #3;
    rst_n = 1'b0;
    #1;
    chk("t6_rst_tready", 32'(tready[0]), 32'd0);
    chk("t6_rst_wr", 32'(wr_en[0]), 32'd0);
    chk("t6_rst_pifo", 32'(pifo_en[0]), 32'd0);
    chk("t6_rst_valid", 32'(mvalid[0]), 32'd0);
    chk("t6_rst_cnt", 32'(cnt0), 32'd0);
    chk("t6_rst_state", 32'(st[0]), 32'(ST_IDLE));
    tvalid[0] = 1'b0;
    @(negedge clk);
    do_reset();

    // random traffic on both instances
    rand_en = 1;
    fork
      for (int k = 0; k < 150; k++) begin
        send_pkt(0, NP'($urandom_range(0, 31)), $urandom_range(1, 4), 1'($urandom));
        if ($urandom_range(0, 3) == 0) idle(0, $urandom_range(1, 3));
      end
      for (int k = 0; k < 150; k++) begin
        send_pkt(1, NP'($urandom_range(0, 31)), $urandom_range(1, 4), 1'($urandom));
        if ($urandom_range(0, 3) == 0) idle(1, $urandom_range(1, 3));
      end
    join
    rand_en = 0;
    for (int i = 0; i < 2; i++) begin
      baf[i] = '0;
      pff[i] = '0;
    end
    idle(0, 0);
    idle(1, 4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

endmodule
